elixirchip_es1_spu_op_srl: RTL and testbench

//  Logical/arithmetic right-shift SPU operator: the inverse-direction companion of the SPU shift-left op.

---
 rtl/elixirchip_es1_spu_op_srl.sv | 126 ++++++++++++
 tb/tb_elixirchip_es1_spu_op_srl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/elixirchip_es1_spu_op_srl.sv
// elixirchip_es1_spu_op_srl
//   Right-shift SPU operator (SRL or SRA) behind a LATENCY-stage,
//   cke-gated pipeline with clear and hold semantics.
//   Optional build macro: ELIXIRCHIP_ES1_SPU_SRL_SPLIT_EN
//     When defined and LATENCY>=2, the barrel shifter is split into a
//     coarse stage (high half of s_shift) and a fine stage (low half).
//     The output timing and values are identical to the unsplit build.
module elixirchip_es1_spu_op_srl #(
    parameter int                    LATENCY         = 1,
    parameter int                    DATA_BITS       = 8,
    parameter int                    MAX_SHIFT       = DATA_BITS,
    parameter int                    SHIFT_BITS      = $clog2(MAX_SHIFT + 1),
    parameter bit                    ARITHMETIC      = 1'b0,
    parameter logic [DATA_BITS-1:0]  CLEAR_DATA      = '1,
    parameter bit                    IMMEDIATE_SHIFT = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cke,
    input  logic [SHIFT_BITS-1:0]  s_shift,
    input  logic [DATA_BITS-1:0]   s_data,
    input  logic                   s_clear,
    input  logic                   s_valid,
    output logic [DATA_BITS-1:0]   m_data,
    output logic                   m_valid
);

    // Right shift by amt, filling vacated upper bits with fill; amounts of
    // DATA_BITS or more leave nothing but fill bits.
    function automatic logic [DATA_BITS-1:0] shr(
        input logic [DATA_BITS-1:0] d,
        input int                   amt,
        input logic                 fill
    );
        logic [DATA_BITS-1:0] r;
        if (amt >= DATA_BITS) begin
            r = {DATA_BITS{fill}};
        end else begin
            r = (d >> amt) | (fill ? ~({DATA_BITS{1'b1}} >> amt) : '0);
        end
        return r;
    endfunction

    // The shift amount is treated as a live input; a constant one folds away.
    logic unused_imm;
    assign unused_imm = IMMEDIATE_SHIFT;

    // Fill bit for the vacated positions: sign for SRA, zero for SRL.
    logic sign_p0;
    assign sign_p0 = ARITHMETIC & s_data[DATA_BITS-1];

    if (LATENCY == 0) begin : g_comb
        // Purely combinational: clear, valid and all clocking are ignored.
        logic unused_ctl;
        assign unused_ctl = &{1'b0, clk, reset_n, cke, s_clear, s_valid};
        assign m_data     = shr(s_data, int'(s_shift), sign_p0);
        assign m_valid    = 1'b1;
    end else begin : g_pipe
`ifdef ELIXIRCHIP_ES1_SPU_SRL_SPLIT_EN
        localparam bit SPLIT = (LATENCY >= 2);
`else
        localparam bit SPLIT = 1'b0;
`endif
        localparam int LO_BITS = SHIFT_BITS / 2;
        localparam int LO_MASK = (1 << LO_BITS) - 1;

        logic [DATA_BITS-1:0] data_p [1:LATENCY];
        logic                 vld_p  [1:LATENCY];
        logic [DATA_BITS-1:0] shift_p0;
        logic [DATA_BITS-1:0] fine_data;

        if (SPLIT) begin : g_split
            logic                  clr_p1;
            logic                  sign_p1;
            logic [SHIFT_BITS-1:0] fine_p1;

            // Stage 1 only applies the coarse (high-half) part of the shift.
            assign shift_p0 = shr(s_data, int'(s_shift) & ~LO_MASK, sign_p0);

            // Carry the clear flag, fill bit and fine shift alongside stage 1.
            always_ff @(posedge clk) begin
                if (cke && (s_clear || s_valid)) begin
                    clr_p1  <= s_clear;
                    sign_p1 <= sign_p0;
                    fine_p1 <= s_shift & SHIFT_BITS'(LO_MASK);
                end
            end

            // Stage 2 finishes the shift, or substitutes the clear value.
            assign fine_data = clr_p1 ? CLEAR_DATA
                                      : shr(data_p[1], int'(fine_p1), sign_p1);
        end else begin : g_full
            assign shift_p0  = shr(s_data, int'(s_shift), sign_p0);
            assign fine_data = data_p[1];
        end

        // Pipeline: stage 1 captures clear/shift; later stages copy only valid data.
        always_ff @(posedge clk) begin
            if (cke) begin
                if (!reset_n) begin
                    for (int k = 1; k <= LATENCY; k++) begin
                        data_p[k] <= CLEAR_DATA;
                        vld_p[k]  <= 1'b0;
                    end
                end else begin
                    if (s_clear) begin
                        data_p[1] <= CLEAR_DATA;
                    end else if (s_valid) begin
                        data_p[1] <= shift_p0;
                    end
                    vld_p[1] <= s_clear | s_valid;
                    for (int k = 2; k <= LATENCY; k++) begin
                        if (vld_p[k-1]) begin
                            data_p[k] <= (SPLIT && k == 2) ? fine_data : data_p[k-1];
                        end
                        vld_p[k] <= vld_p[k-1];
                    end
                end
            end
        end

        assign m_data  = data_p[LATENCY];
        assign m_valid = vld_p[LATENCY];
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_srl.sv
// tb_elixirchip_es1_spu_op_srl
//   Drives an SRL (LATENCY=1), an SRA (LATENCY=1) and an SRL (LATENCY=3)
//   instance from shared operands and compares them against a token-level
//   reference model kept in this file.
module tb_elixirchip_es1_spu_op_srl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cke_a = 1'b1;
    logic       cke_b = 1'b1;
    logic [3:0] s_shift = '0;
    logic [7:0] s_data = '0;
    logic       s_clear = 1'b0;
    logic       s_valid = 1'b0;

    logic [7:0] m_data_srl, m_data_sra, m_data_l3;
    logic       m_valid_srl, m_valid_sra, m_valid_l3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_srl #(.LATENCY(1), .DATA_BITS(8), .ARITHMETIC(1'b0)) u_srl (
        .clk(clk), .reset_n(reset_n), .cke(cke_a), .s_shift(s_shift), .s_data(s_data),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m_data_srl), .m_valid(m_valid_srl));

    elixirchip_es1_spu_op_srl #(.LATENCY(1), .DATA_BITS(8), .ARITHMETIC(1'b1)) u_sra (
        .clk(clk), .reset_n(reset_n), .cke(cke_a), .s_shift(s_shift), .s_data(s_data),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m_data_sra), .m_valid(m_valid_sra));

    elixirchip_es1_spu_op_srl #(.LATENCY(3), .DATA_BITS(8), .ARITHMETIC(1'b0)) u_l3 (
        .clk(clk), .reset_n(reset_n), .cke(cke_b), .s_shift(s_shift), .s_data(s_data),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m_data_l3), .m_valid(m_valid_l3));

    // Reference model: each instance is a list of in-flight tokens.
    int         lat_m [3] = '{1, 1, 3};
    bit         ar_m  [3] = '{1'b0, 1'b1, 1'b0};
    bit         tv    [3][3];
    logic [7:0] tval  [3][3];
    logic [7:0] od    [3];
    bit         ov    [3];

    // Shift as division by a power of two (floor for signed operands).
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh, input bit ar);
        int v, p, q;
        v = ar ? int'($signed(d)) : int'(d);
        if (sh > 8) sh = 8;
        p = 1 << sh;
        if (v >= 0) q = v / p;
        else        q = -((-v + p - 1) / p);
        return q[7:0];
    endfunction

    task automatic model_edge(input int i, input logic ck);
        if (!ck) return;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) tv[i][k] = 1'b0;
            od[i] = 8'hFF;
            ov[i] = 1'b0;
        end else begin
            for (int k = 2; k > 0; k--) begin
                tv[i][k]   = tv[i][k-1];
                tval[i][k] = tval[i][k-1];
            end
            tv[i][0]   = s_clear | s_valid;
            tval[i][0] = s_clear ? 8'hFF : ref_shift(s_data, int'(s_shift), ar_m[i]);
            ov[i] = tv[i][lat_m[i]-1];
            if (ov[i]) od[i] = tval[i][lat_m[i]-1];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: sample after the edge, advance the model, compare all outputs.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge(0, cke_a);
        model_edge(1, cke_a);
        model_edge(2, cke_b);
        chk("srl_data",  m_data_srl,  od[0]);
        chk("srl_valid", m_valid_srl, ov[0]);
        chk("sra_data",  m_data_sra,  od[1]);
        chk("sra_valid", m_valid_sra, ov[1]);
        chk("l3_data",   m_data_l3,   od[2]);
        chk("l3_valid",  m_valid_l3,  ov[2]);
    endtask

    task automatic op(input logic [7:0] d, input logic [3:0] sh, input logic clr, input logic vld);
        s_data  = d;
        s_shift = sh;
        s_clear = clr;
        s_valid = vld;
    endtask

    logic [7:0] burst_q[$];
    logic [7:0] burst_exp [4] = '{8'h80, 8'h40, 8'h20, 8'h01};
    logic [3:0] burst_sh  [4] = '{4'd0, 4'd1, 4'd2, 4'd7};
    logic       seen;

    initial begin
        for (int i = 0; i < 3; i++) begin
            od[i] = 8'hFF;
            ov[i] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tv[i][k]   = 1'b0;
                tval[i][k] = 8'h00;
            end
        end

        // Reset for two cycles, then idle.
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("rst_srl_data",  m_data_srl, 8'hFF);
        chk("rst_srl_valid", m_valid_srl, 1'b0);
        chk("rst_l3_data",   m_data_l3, 8'hFF);
        step();
        step();
        chk("idle_srl_data", m_data_srl, 8'hFF);

        // Directed shifts.
        op(8'hB4, 4'd2, 1'b0, 1'b1); step();
        chk("srl_b4_2", m_data_srl, 8'h2D);
        chk("srl_b4_2_valid", m_valid_srl, 1'b1);
        op(8'hB4, 4'd8, 1'b0, 1'b1); step();
        chk("srl_b4_8", m_data_srl, 8'h00);
        chk("sra_b4_8", m_data_sra, 8'hFF);
        op(8'hB4, 4'd3, 1'b0, 1'b1); step();
        chk("sra_b4_3", m_data_sra, 8'hF6);
        op(8'h34, 4'd8, 1'b0, 1'b1); step();
        chk("sra_34_8", m_data_sra, 8'h00);

        // Clear beats valid, then hold.
        op(8'h10, 4'd1, 1'b1, 1'b1); step();
        chk("clr_srl", m_data_srl, 8'hFF);
        chk("clr_sra", m_data_sra, 8'hFF);
        chk("clr_valid", m_valid_srl, 1'b1);
        op(8'($urandom), 4'($urandom_range(0, 8)), 1'b0, 1'b0); step();
        chk("hold_data", m_data_srl, 8'hFF);
        chk("hold_valid", m_valid_srl, 1'b0);

        // LATENCY=3 burst with cke toggling 1,0 per operation.
        for (int i = 0; i < 4; i++) step();
        burst_q.delete();
        for (int i = 0; i < 4; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                cke_b = (ph == 0);
                op(8'h80, burst_sh[i], 1'b0, 1'b1);
                step();
                if (cke_b && m_valid_l3) burst_q.push_back(m_data_l3);
            end
        end
        op(8'h00, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cke_b = i[0];
            step();
            if (cke_b && m_valid_l3) burst_q.push_back(m_data_l3);
        end
        cke_b = 1'b1;
        chk("burst_count", burst_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < burst_q.size()) chk("burst_val", burst_q[i], burst_exp[i]);
        end

        // Reset with two ops in flight on the LATENCY=3 instance.
        op(8'h80, 4'd0, 1'b0, 1'b1); step();
        op(8'h80, 4'd1, 1'b0, 1'b1); step();
        op(8'h00, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b0; step();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen |= m_valid_l3;
        end
        chk("rst_drop_valid", seen, 1'b0);
        chk("rst_drop_data", m_data_l3, 8'hFF);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 39) != 0);
            cke_a   = ($urandom_range(0, 3) != 0);
            cke_b   = ($urandom_range(0, 2) != 0);
            op(8'($urandom), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
